stimulus_sequencer: RTL and testbench
=====================================

Name: stimulus_sequencer

Overview:
Parametrised, synthesizable replacement for hand-written timed stimulus blocks in monitor testbenches. It replays a loaded table of timestamped input events into a topEntity monitor's input_i / new_input_i pairs. Supports multiple input channels, configurable data width and table depth, per-event channel masks, loop mode and abort. It sits between a bench or host loader and the monitor's input ports.

Parameters:
NUM_INPUTS, 1, number of monitor input streams driven
DATA_WIDTH, 64, width of each input value (two's complement)
DEPTH, 16, number of event table entries; power of two, >= 2
DELTA_WIDTH, 32, width of the per-event wait counter (cycles)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable; when low, all state is frozen
load_we  in  1  table write strobe
load_addr  in  $clog2(DEPTH)  table write address
load_delta  in  DELTA_WIDTH  enabled cycles to wait after the previous issue (or after start)
load_mask  in  NUM_INPUTS  channels receiving a new value in this event
load_data  in  NUM_INPUTS*DATA_WIDTH  channel values; channel i = bits [i*DATA_WIDTH +: DATA_WIDTH]
num_events  in  $clog2(DEPTH)+1  events to replay, sampled at start; valid range 1..DEPTH
start  in  1  begin replay (1-cycle pulse)
loop  in  1  restart from entry 0 after the last entry; sampled at start
abort  in  1  return to IDLE
input_data  out  NUM_INPUTS*DATA_WIDTH  registered values to the monitor
new_input  out  NUM_INPUTS  registered per-channel new-value strobes
busy  out  1  high in WAIT/ISSUE
done  out  1  1-cycle pulse after the last event of a non-loop run
event_idx  out  $clog2(DEPTH)  index of the entry currently pending

Behaviour:
- Reset: async, takes effect immediately. State=IDLE. input_data=0, new_input=0, busy=0, done=0, event_idx=0, counter=0. Table contents are not reset.
- en=0: FSM, counter and outputs hold. new_input is forced to 0 combinationally after the register, so no strobe is ever visible while en=0. A pending issue is deferred, not dropped.
- Table write: when load_we=1 and state=IDLE, write {delta, mask, data} at load_addr. Writes while busy are ignored.
- FSM states: IDLE, WAIT, ISSUE, DONE.
- IDLE: start=1 with 1<=num_events<=DEPTH latches num_events and loop, sets event_idx=0, counter=delta[0], and goes to WAIT. start with num_events=0 or >DEPTH is ignored.
- WAIT: if counter!=0, decrement by 1 per enabled cycle. If counter==0, go to ISSUE.
- ISSUE (one cycle):
  - Register new_input=mask[idx] and, for masked channels, input_data=data[idx]. Unmasked channels are driven 0.
  - If idx is the last entry and loop=1, next idx=0.
  - If idx is the last entry and loop=0, go to DONE.
  - Otherwise idx+1, counter=delta[next], go to WAIT.
- Outputs return to 0 the enabled cycle after a strobe. Each strobe is exactly one enabled cycle wide.
- Timing: start sampled at edge k; the first strobe is high in the cycle after edge k+1+delta[0]. Consecutive strobes are spaced delta[n]+2 cycles apart. delta=0 gives a spacing of 2 cycles.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy: ignored.
- abort: highest priority over start, load and issue. Next state=IDLE; outputs, busy and done are cleared at the next edge. A strobe scheduled for the same edge is suppressed.
- mask=0 entry: consumes its time slot, no strobe.
- counter arithmetic is unsigned with no wrap; it saturates at 0.

Test Plan:
- Single channel, table {(998,1,1),(298,1,2),(98,1,3)}, num_events=3, start at edge 10 -> new_input strobes with input_data=1,2,3 at cycles 1009,1309,1409; done pulse at cycle 1410; input_data=0 between strobes.
- NUM_INPUTS=3, DATA_WIDTH=16, entry (5, mask=3'b101, data {7,-1,-4}) -> single strobe new_input=3'b101; ch0=-4, ch1=0, ch2=7.
- en held low for 20 cycles mid-WAIT with delta=50 -> strobe delayed by exactly 20 cycles; no strobe while en=0.
- loop=1, two entries with delta=0 -> strobes alternate data[0], data[1] every 2 cycles indefinitely; abort -> IDLE next cycle, busy=0, no further strobes.
- Async rst asserted mid-WAIT -> outputs 0 immediately. After release, start with the unchanged table replays from entry 0 with the original timing.
- start with num_events=0, and load_we while busy -> no state change; the table entry is unchanged when read back via replay.

Source files
------------

// File: rtl/stimulus_sequencer.sv
// Replays a loaded table of timestamped events onto a monitor's input/new_input pairs.
// Each entry waits `delta` enabled cycles, then issues a one-cycle strobe on its masked channels.
module stimulus_sequencer #(
  parameter int unsigned NUM_INPUTS  = 1,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DELTA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             load_we,
  input  logic [$clog2(DEPTH)-1:0]         load_addr,
  input  logic [DELTA_WIDTH-1:0]           load_delta,
  input  logic [NUM_INPUTS-1:0]            load_mask,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] load_data,
  input  logic [$clog2(DEPTH):0]           num_events,
  input  logic                             start,
  input  logic                             loop,
  input  logic                             abort,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data,
  output logic [NUM_INPUTS-1:0]            new_input,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(DEPTH)-1:0]         event_idx
);

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned NumW  = IdxW + 1;
  localparam int unsigned DataW = NUM_INPUTS * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StIssue, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DELTA_WIDTH-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d, idx_inc;
  logic [NumW-1:0]        num_q, num_d;
  logic                   loop_q, loop_d;
  logic [DataW-1:0]       data_q, data_d;
  logic [NUM_INPUTS-1:0]  new_q, new_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mem_we, num_ok, is_last;

  logic [DELTA_WIDTH-1:0] delta_mem [DEPTH];
  logic [NUM_INPUTS-1:0]  mask_mem  [DEPTH];
  logic [DataW-1:0]       data_mem  [DEPTH];

  assign idx_inc = idx_q + IdxW'(1);
  assign num_ok  = (num_events != '0) && (num_events <= NumW'(DEPTH));
  assign is_last = ((NumW'(idx_q) + NumW'(1)) == num_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    num_d   = num_q;
    loop_d  = loop_q;
    data_d  = data_q;
    new_d   = new_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mem_we  = 1'b0;
    if (en) begin
      // Strobes, data and done are all single enabled-cycle pulses.
      new_d  = '0;
      data_d = '0;
      done_d = 1'b0;
      if (abort) begin
        state_d = StIdle;
        busy_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            mem_we = load_we;
            if (start && num_ok) begin
              num_d   = num_events;
              loop_d  = loop;
              idx_d   = '0;
              cnt_d   = delta_mem[0];
              busy_d  = 1'b1;
              state_d = StWait;
            end
          end
          StWait: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - DELTA_WIDTH'(1);
            end else begin
              state_d = StIssue;
              new_d   = mask_mem[idx_q];
              for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = mask_mem[idx_q][i] ?
                    data_mem[idx_q][i*DATA_WIDTH +: DATA_WIDTH] : '0;
              end
            end
          end
          StIssue: begin
            if (is_last && !loop_q) begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (is_last) begin
              idx_d   = '0;
              cnt_d   = delta_mem[0];
              state_d = StWait;
            end else begin
              idx_d   = idx_inc;
              cnt_d   = delta_mem[idx_inc];
              state_d = StWait;
            end
          end
          StDone: state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      loop_q  <= 1'b0;
      data_q  <= '0;
      new_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      loop_q  <= loop_d;
      data_q  <= data_d;
      new_q   <= new_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Table is deliberately not reset so a replay survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      delta_mem[load_addr] <= load_delta;
      mask_mem[load_addr]  <= load_mask;
      data_mem[load_addr]  <= load_data;
    end
  end

  assign input_data = data_q;
  assign new_input  = new_q & {NUM_INPUTS{en}};
  assign busy       = busy_q;
  assign done       = done_q;
  assign event_idx  = idx_q;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Bench for stimulus_sequencer: a schedule-based model checked every cycle, plus
// hand-computed strobe times and values for each directed scenario.
module tb_stimulus_sequencer;

  localparam int unsigned NI    = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DLW   = 32;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned NW    = AW + 1;

  logic              clk = 1'b0;
  logic              rst, en, load_we, start, loop, abort;
  logic [AW-1:0]     load_addr;
  logic [DLW-1:0]    load_delta;
  logic [NI-1:0]     load_mask;
  logic [NI*DW-1:0]  load_data;
  logic [NW-1:0]     num_events;
  logic [NI*DW-1:0]  input_data;
  logic [NI-1:0]     new_input;
  logic              busy, done;
  logic [AW-1:0]     event_idx;

  stimulus_sequencer #(
    .NUM_INPUTS (NI),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .DELTA_WIDTH(DLW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_delta(load_delta),
    .load_mask (load_mask),
    .load_data (load_data),
    .num_events(num_events),
    .start     (start),
    .loop      (loop),
    .abort     (abort),
    .input_data(input_data),
    .new_input (new_input),
    .busy      (busy),
    .done      (done),
    .event_idx (event_idx)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: absolute schedule in enabled ticks ----------------
  logic [DLW-1:0]   t_delta [DEPTH];
  logic [NI-1:0]    t_mask  [DEPTH];
  logic [NI*DW-1:0] t_data  [DEPTH];
  int               m_tick, m_next, m_idx, m_num, e_idx;
  bit               m_active, m_loop, e_busy, e_done;
  logic [NI-1:0]    e_new;
  logic [NI*DW-1:0] e_data;

  task automatic model_reset();
    m_active = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = 0;
    e_new = '0; e_data = '0; m_tick = 0;
  endtask

  // Predicts the outputs after the next posedge from the inputs it will sample.
  task automatic model_step();
    bit idle_now;
    if (!en) return;
    m_tick++;
    idle_now = !m_active && !e_done;
    e_new = '0; e_data = '0; e_done = 1'b0;
    if (abort) begin
      m_active = 1'b0; e_busy = 1'b0; e_idx = 0;
    end else if (idle_now) begin
      if (start && num_events >= 1 && num_events <= NW'(DEPTH)) begin
        m_active = 1'b1; m_num = int'(num_events); m_loop = loop;
        m_idx = 0; e_idx = 0; e_busy = 1'b1;
        m_next = m_tick + 1 + int'(t_delta[0]);
      end
      if (load_we) begin
        t_delta[load_addr] = load_delta;
        t_mask[load_addr]  = load_mask;
        t_data[load_addr]  = load_data;
      end
    end else if (m_active) begin
      if (m_tick == m_next) begin
        e_new = t_mask[m_idx];
        for (int c = 0; c < int'(NI); c++)
          e_data[c*DW +: DW] = t_mask[m_idx][c] ? t_data[m_idx][c*DW +: DW] : '0;
      end else if (m_tick == m_next + 1) begin
        if (m_idx == m_num - 1 && !m_loop) begin
          m_active = 1'b0; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          m_idx  = (m_idx == m_num - 1) ? 0 : m_idx + 1;
          e_idx  = m_idx;
          m_next = m_tick + 1 + int'(t_delta[m_idx]);
        end
      end
    end
  endtask

  initial model_reset();

  initial forever begin
    @(negedge clk);
    if (rst) model_reset();
    check("cycle{new,data,busy,done,idx}",
          64'({new_input, input_data, busy, done, event_idx}),
          64'({e_new & {NI{en}}, e_data, e_busy, e_done, AW'(e_idx)}));
    if (!rst) model_step();
  end

  // ---------------- observation logs ----------------
  int               s_edge[$];
  logic [NI-1:0]    s_mask[$];
  logic [NI*DW-1:0] s_data[$];
  int               d_edge[$];

  initial forever begin
    @(negedge clk);
    if (new_input != '0) begin
      s_edge.push_back(edge_cnt); s_mask.push_back(new_input); s_data.push_back(input_data);
    end
    if (done) d_edge.push_back(edge_cnt);
  end

  task automatic clear_logs();
    s_edge.delete(); s_mask.delete(); s_data.delete(); d_edge.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int addr, input int delta, input logic [NI-1:0] mask,
                      input logic [NI*DW-1:0] data);
    load_we = 1'b1; load_addr = AW'(addr); load_delta = DLW'(delta);
    load_mask = mask; load_data = data;
    tick(1);
    load_we = 1'b0;
  endtask

  task automatic start_run(input int n, input logic lp, output int k);
    num_events = NW'(n); loop = lp; start = 1'b1;
    tick(1);
    start = 1'b0;
    k = edge_cnt;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (d_edge.size() == 0 && n < bound) begin tick(1); n++; end
    if (d_edge.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: timeout, got no done pulse expected one within %0d cycles", name, bound);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int k;
  int n_seen;
  int exp_t1[3] = '{999, 1299, 1399};

  initial begin
    rst = 1'b1; en = 1'b1; load_we = 1'b0; start = 1'b0; loop = 1'b0; abort = 1'b0;
    load_addr = '0; load_delta = '0; load_mask = '0; load_data = '0; num_events = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset new_input", 64'(new_input), 64'd0);
    check("reset input_data", 64'(input_data), 64'd0);
    check("reset busy/done", 64'({busy, done}), 64'd0);
    check("reset event_idx", 64'(event_idx), 64'd0);

    // Three-entry single-channel replay.
    load(0, 998, 3'b001, 48'd1);
    load(1, 298, 3'b001, 48'd2);
    load(2, 98, 3'b001, 48'd3);
    clear_logs();
    start_run(3, 1'b0, k);
    wait_done("t1 done", 1600);
    check("t1 strobe count", 64'(s_edge.size()), 64'd3);
    for (int i = 0; i < 3 && i < s_edge.size(); i++) begin
      check("t1 strobe time", 64'(s_edge[i] - k), 64'(exp_t1[i]));
      check("t1 strobe data", 64'(s_data[i]), 64'(i + 1));
      check("t1 strobe mask", 64'(s_mask[i]), 64'b001);
    end
    if (d_edge.size() > 0) check("t1 done time", 64'(d_edge[0] - k), 64'd1400);
    tick(2);

    // Multi-channel masked entry with a negative value.
    load(0, 5, 3'b101, {16'd7, 16'hFFFF, 16'hFFFC});
    clear_logs();
    start_run(1, 1'b0, k);
    wait_done("t2 done", 50);
    check("t2 strobe count", 64'(s_edge.size()), 64'd1);
    if (s_edge.size() > 0) begin
      check("t2 strobe time", 64'(s_edge[0] - k), 64'd6);
      check("t2 strobe mask", 64'(s_mask[0]), 64'b101);
      check("t2 strobe data", 64'(s_data[0]), 64'h0007_0000_FFFC);
    end
    if (d_edge.size() > 0) check("t2 done time", 64'(d_edge[0] - k), 64'd7);
    tick(2);

    // en low for 20 cycles in the middle of a 50-cycle wait.
    load(0, 50, 3'b001, 48'd9);
    clear_logs();
    start_run(1, 1'b0, k);
    tick(10);
    en = 1'b0;
    tick(20);
    en = 1'b1;
    wait_done("t3 done", 100);
    check("t3 strobe count", 64'(s_edge.size()), 64'd1);
    if (s_edge.size() > 0) begin
      check("t3 strobe time", 64'(s_edge[0] - k), 64'd71);
      check("t3 strobe data", 64'(s_data[0]), 64'd9);
    end
    tick(2);

    // Loop over two zero-delta entries, then abort on a strobe edge.
    load(0, 0, 3'b001, 48'h11);
    load(1, 0, 3'b001, 48'h22);
    clear_logs();
    start_run(2, 1'b1, k);
    tick(20);
    check("t4 strobe count", 64'(s_edge.size()), 64'd10);
    if (s_edge.size() > 0) check("t4 first strobe", 64'(s_edge[0] - k), 64'd1);
    for (int i = 0; i < s_edge.size(); i++) begin
      check("t4 loop data", 64'(s_data[i]), (i % 2 == 0) ? 64'h11 : 64'h22);
      if (i > 0) check("t4 spacing", 64'(s_edge[i] - s_edge[i-1]), 64'd2);
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4 busy after abort", 64'(busy), 64'd0);
    n_seen = s_edge.size();
    tick(10);
    check("t4 no strobe after abort", 64'(s_edge.size()), 64'(n_seen));
    check("t4 idle after abort", 64'({busy, done, event_idx}), 64'd0);

    // Asynchronous reset mid-wait, then replay from the untouched table.
    load(0, 30, 3'b001, 48'd5);
    clear_logs();
    start_run(1, 1'b0, k);
    tick(10);
    rst = 1'b1;
    #1;
    check("t5 busy on rst", 64'(busy), 64'd0);
    check("t5 outputs on rst", 64'({new_input, input_data, done, event_idx}), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    start_run(1, 1'b0, k);
    wait_done("t5 done", 60);
    check("t5 strobe count", 64'(s_edge.size()), 64'd1);
    if (s_edge.size() > 0) begin
      check("t5 strobe time", 64'(s_edge[0] - k), 64'd31);
      check("t5 strobe data", 64'(s_data[0]), 64'd5);
    end
    tick(2);

    // Invalid starts and writes while busy are ignored.
    start_run(0, 1'b0, k);
    check("t6 busy num=0", 64'(busy), 64'd0);
    start_run(17, 1'b0, k);
    check("t6 busy num=17", 64'(busy), 64'd0);
    clear_logs();
    start_run(1, 1'b0, k);
    tick(3);
    load(0, 0, 3'b011, 48'd99);
    wait_done("t6 done a", 60);
    tick(2);
    clear_logs();
    start_run(1, 1'b0, k);
    wait_done("t6 done b", 60);
    check("t6 strobe count", 64'(s_edge.size()), 64'd1);
    if (s_edge.size() > 0) begin
      check("t6 strobe time", 64'(s_edge[0] - k), 64'd31);
      check("t6 strobe mask", 64'(s_mask[0]), 64'b001);
      check("t6 strobe data", 64'(s_data[0]), 64'd5);
    end
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
